// File: rtl/jpeg_dc_encoder.sv
// rtl/jpeg_dc_encoder.sv - streaming DC-only JPEG entropy encoder for 8x8 grayscale blocks
module jpeg_dc_encoder #(
    parameter int IMG_W      = 128,
    parameter int IMG_H      = 128,
    parameter int Q_SHIFT    = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       full
);
    localparam int XW   = $clog2(IMG_W);
    localparam int YW   = $clog2(IMG_H);
    localparam int NBLK = IMG_W / 8;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam logic signed [15:0] Q_RND = 16'(1 << (2 + Q_SHIFT));

    // ---------------- pixel counting and block accumulation ----------------
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [13:0]   acc [NBLK];
    logic [13:0]   acc_cur;
    logic          blk_start, blk_done;
    logic [13:0]   s_sum;
    logic          s_valid, s_first, s_last;

    assign acc_cur   = acc[x[XW-1:3]];
    assign blk_start = (x[2:0] == 3'd0) && (y[2:0] == 3'd0);
    assign blk_done  = (x[2:0] == 3'd7) && (y[2:0] == 3'd7);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            x       <= '0;
            y       <= '0;
            s_sum   <= '0;
            s_valid <= 1'b0;
            s_first <= 1'b0;
            s_last  <= 1'b0;
            for (int i = 0; i < NBLK; i++) acc[i] <= '0;
        end else begin
            s_valid <= 1'b0;
            if (din_valid) begin
                acc[x[XW-1:3]] <= blk_start ? {6'd0, din} : acc_cur + {6'd0, din};
                if (blk_done) begin
                    s_valid <= 1'b1;
                    s_sum   <= acc_cur + {6'd0, din};
                    s_first <= (x == XW'(7)) && (y == YW'(7));
                    s_last  <= (x == XW'(IMG_W - 1)) && (y == YW'(IMG_H - 1));
                end
                if (x == XW'(IMG_W - 1)) begin
                    x <= '0;
                    y <= (y == YW'(IMG_H - 1)) ? '0 : y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
            end
        end
    end

    // ---------------- quantize, DPCM and Huffman-code one block ----------------
    logic signed [15:0] t_sum, dc, diff, amp_src, pred;
    logic [11:0]        mag;
    logic [3:0]         cat;
    logic [15:0]        amp;
    logic [8:0]         hcode;
    logic [3:0]         hlen;
    logic [31:0]        enc_bits_n, enc_bits;
    logic [5:0]         enc_len_n, enc_len;
    logic               enc_valid, enc_last;

    always_comb begin
        t_sum   = $signed({2'b00, s_sum}) - 16'sd8192 + Q_RND;
        dc      = t_sum >>> (3 + Q_SHIFT);
        // First block of an image predicts from zero regardless of the previous image.
        diff    = dc - (s_first ? 16'sd0 : pred);
        mag     = diff[15] ? 12'(-diff) : diff[11:0];
        cat     = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (mag[i]) cat = 4'(i + 1);
        end
        amp_src = diff[15] ? diff - 16'sd1 : diff;
        amp     = amp_src & ((16'd1 << cat) - 16'd1);
        case (cat)
            4'd0:    begin hcode = 9'b000000000; hlen = 4'd2; end
            4'd1:    begin hcode = 9'b000000010; hlen = 4'd3; end
            4'd2:    begin hcode = 9'b000000011; hlen = 4'd3; end
            4'd3:    begin hcode = 9'b000000100; hlen = 4'd3; end
            4'd4:    begin hcode = 9'b000000101; hlen = 4'd3; end
            4'd5:    begin hcode = 9'b000000110; hlen = 4'd3; end
            4'd6:    begin hcode = 9'b000001110; hlen = 4'd4; end
            4'd7:    begin hcode = 9'b000011110; hlen = 4'd5; end
            4'd8:    begin hcode = 9'b000111110; hlen = 4'd6; end
            4'd9:    begin hcode = 9'b001111110; hlen = 4'd7; end
            4'd10:   begin hcode = 9'b011111110; hlen = 4'd8; end
            default: begin hcode = 9'b111111110; hlen = 4'd9; end
        endcase
        enc_bits_n = (((32'(hcode) << cat) | 32'(amp)) << 4) | 32'hA;
        enc_len_n  = 6'(hlen) + 6'(cat) + 6'd4;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pred      <= '0;
            enc_bits  <= '0;
            enc_len   <= '0;
            enc_valid <= 1'b0;
            enc_last  <= 1'b0;
        end else begin
            enc_valid <= s_valid;
            if (s_valid) begin
                pred     <= dc;
                enc_bits <= enc_bits_n;
                enc_len  <= enc_len_n;
                enc_last <= s_last;
            end
        end
    end

    // ---------------- bit packer with byte stuffing and EOI ----------------
    typedef enum logic [1:0] {PK_RUN, PK_STUFF, PK_EOI} pk_state_t;
    pk_state_t   pk_state, pk_state_n;
    logic [63:0] bbuf, bbuf_n;
    logic [6:0]  bcnt, bcnt_n, bcnt_rem;
    logic        eoi_pend, eoi_pend_n;
    logic        push;
    logic [7:0]  push_data, pad_byte;
    logic [3:0]  pad_sh;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pk_state <= PK_RUN;
            bbuf     <= '0;
            bcnt     <= '0;
            eoi_pend <= 1'b0;
        end else begin
            pk_state <= pk_state_n;
            bbuf     <= bbuf_n;
            bcnt     <= bcnt_n;
            eoi_pend <= eoi_pend_n;
        end
    end

    // Valid bits sit right-aligned in bbuf, oldest at bit bcnt-1; bits above are don't-care.
    always_comb begin
        pk_state_n = pk_state;
        eoi_pend_n = eoi_pend;
        push       = 1'b0;
        push_data  = 8'h00;
        bcnt_rem   = bcnt;
        pad_sh     = 4'd8 - {1'b0, bcnt[2:0]};
        pad_byte   = (bbuf[7:0] << pad_sh) | (8'hFF >> bcnt[2:0]);
        case (pk_state)
            PK_STUFF: begin
                push       = 1'b1;
                push_data  = 8'h00;
                pk_state_n = PK_RUN;
            end
            PK_EOI: begin
                push       = 1'b1;
                push_data  = 8'hD9;
                pk_state_n = PK_RUN;
            end
            default: begin
                if (bcnt >= 7'd8) begin
                    push      = 1'b1;
                    push_data = 8'(bbuf >> (bcnt - 7'd8));
                    bcnt_rem  = bcnt - 7'd8;
                    if (push_data == 8'hFF) pk_state_n = PK_STUFF;
                end else if (eoi_pend) begin
                    push = 1'b1;
                    if (bcnt != 7'd0) begin
                        push_data = pad_byte;
                        bcnt_rem  = 7'd0;
                        if (pad_byte == 8'hFF) pk_state_n = PK_STUFF;
                    end else begin
                        push_data  = 8'hFF;
                        eoi_pend_n = 1'b0;
                        pk_state_n = PK_EOI;
                    end
                end
            end
        endcase
        bbuf_n = bbuf;
        bcnt_n = bcnt_rem;
        if (enc_valid) begin
            bbuf_n = (bbuf << enc_len) | 64'(enc_bits);
            bcnt_n = bcnt_rem + 7'(enc_len);
            if (enc_last) eoi_pend_n = 1'b1;
        end
    end

    // ---------------- output byte FIFO ----------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count, count_n;
    logic          pop, wr_en;

    assign pop     = (count != '0);
    assign wr_en   = push && ((count != CW'(FIFO_DEPTH)) || pop);
    assign count_n = count + CW'(wr_en) - CW'(pop);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= push_data;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            dout       <= 8'h00;
            dout_valid <= 1'b0;
            full       <= 1'b0;
        end else begin
            count      <= count_n;
            full       <= (count_n >= CW'(FIFO_DEPTH - 8));
            dout_valid <= pop;
            if (pop) begin
                dout <= mem[rptr];
                rptr <= (rptr == AW'(FIFO_DEPTH - 1)) ? '0 : rptr + AW'(1);
            end
            if (wr_en) wptr <= (wptr == AW'(FIFO_DEPTH - 1)) ? '0 : wptr + AW'(1);
        end
    end
endmodule

// File: tb/tb_jpeg_dc_encoder.sv
// tb/tb_jpeg_dc_encoder.sv - scoreboard bench for jpeg_dc_encoder
module tb_jpeg_dc_encoder;
    localparam int IMG_W   = 128;
    localparam int IMG_H   = 128;
    localparam int Q_SHIFT = 4;
    localparam int NPIX    = IMG_W * IMG_H;

    logic       clk = 1'b0;
    logic       nrst;
    logic [7:0] din;
    logic       din_valid;
    logic [7:0] dout;
    logic       dout_valid;
    logic       full;

    always #5 clk = ~clk;

    jpeg_dc_encoder #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .Q_SHIFT(Q_SHIFT), .FIFO_DEPTH(16)
    ) dut (
        .clk(clk), .nrst(nrst), .din(din), .din_valid(din_valid),
        .dout(dout), .dout_valid(dout_valid), .full(full)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] obs[$];
    int         cyc = 0;
    int         t_blk = 0;
    int         lat = -1;
    int         full_cnt = 0;
    bit         arm_lat = 1'b0;
    bit         lat_armed = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int pat, input int x, input int y);
        int lvl[7] = '{0, 15, 7, 0, 0, 0, 253};
        int bx = x / 8;
        int by = y / 8;
        case (pat)
            0: return 8'h80;
            1: return 8'hFF;
            2: return 8'h00;
            default: begin
                if (by == 0 && bx < 7) return 8'(lvl[bx]);
                return 8'((bx * 37 + by * 11 + x % 8 + 3 * (y % 8)) & 255);
            end
        endcase
    endfunction

    task automatic model_image(input int pat);
        bit         bq[$];
        int         pred, s, dc, diff, mag, cat, amp;
        logic [7:0] b;
        int clen[12] = '{2, 3, 3, 3, 3, 3, 4, 5, 6, 7, 8, 9};
        int cval[12] = '{0, 2, 3, 4, 5, 6, 14, 30, 62, 126, 254, 510};
        pred = 0;
        for (int by = 0; by < IMG_H / 8; by++) begin
            for (int bx = 0; bx < IMG_W / 8; bx++) begin
                s = 0;
                for (int yy = 0; yy < 8; yy++)
                    for (int xx = 0; xx < 8; xx++)
                        s += int'(pix(pat, bx * 8 + xx, by * 8 + yy));
                dc   = (s - 8192 + (1 << (2 + Q_SHIFT))) >>> (3 + Q_SHIFT);
                diff = dc - pred;
                pred = dc;
                mag  = (diff < 0) ? -diff : diff;
                cat  = 0;
                while (mag > 0) begin
                    cat++;
                    mag = mag >> 1;
                end
                for (int i = clen[cat] - 1; i >= 0; i--) bq.push_back(bit'((cval[cat] >> i) & 1));
                amp = (diff < 0) ? diff - 1 : diff;
                for (int i = cat - 1; i >= 0; i--) bq.push_back(bit'((amp >> i) & 1));
                bq.push_back(1'b1); bq.push_back(1'b0); bq.push_back(1'b1); bq.push_back(1'b0);
            end
        end
        while (bq.size() % 8 != 0) bq.push_back(1'b1);
        while (bq.size() > 0) begin
            b = 8'h00;
            for (int i = 0; i < 8; i++) b = {b[6:0], bq.pop_front()};
            exp_q.push_back(b);
            if (b == 8'hFF) exp_q.push_back(8'h00);
        end
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hD9);
    endtask

    task automatic drive_image(input int pat, input int npix);
        for (int i = 0; i < npix; i++) begin
            din       = pix(pat, i % IMG_W, i / IMG_W);
            din_valid = 1'b1;
            @(posedge clk);
            #1;
            if (arm_lat && i == 7 * IMG_W + 7) begin
                t_blk     = cyc;
                lat_armed = 1'b1;
                arm_lat   = 1'b0;
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_remaining", 32'(exp_q.size()), 32'd0);
        repeat (10) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (full === 1'b1) full_cnt++;
        if (dout_valid === 1'b1) begin
            obs.push_back(dout);
            if (lat_armed) begin
                lat       = cyc - t_blk;
                lat_armed = 1'b0;
            end
            if (exp_q.size() == 0) check("unexpected_byte", 32'(dout), 32'hFFFF_FFFF);
            else check("byte", 32'(dout), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        int starts[$];
        int ends[$];
        int st;
        int ndiff;
        nrst      = 1'b0;
        din       = 8'h00;
        din_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        @(posedge clk);
        #1 nrst = 1'b1;
        @(posedge clk);
        #1;

        arm_lat = 1'b1;
        model_image(1); drive_image(1, NPIX);
        model_image(2); drive_image(2, NPIX);
        model_image(3); drive_image(3, NPIX);
        model_image(3); drive_image(3, NPIX);
        drain();
        check("blk_latency_ok", 32'(lat >= 0 && lat <= 12), 32'd1);

        drive_image(2, 800);
        nrst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("midrst_dout_valid", 32'(dout_valid), 32'd0);
        end
        @(posedge clk);
        #1 nrst = 1'b1;
        model_image(0); drive_image(0, NPIX);
        drain();
        check("full_never", 32'(full_cnt), 32'd0);

        st = 0;
        for (int i = 0; i + 1 < obs.size(); i++) begin
            if (obs[i] == 8'hFF && obs[i + 1] == 8'hD9) begin
                starts.push_back(st);
                ends.push_back(i + 2);
                st = i + 2;
                i++;
            end
        end
        check("image_count", 32'(starts.size()), 32'd5);
        check("trailing_bytes", 32'(obs.size() - st), 32'd0);
        if (starts.size() == 5) begin
            check("ff_img_b0", 32'(obs[starts[0]]), 32'hF4);
            check("ff_img_b1", 32'(obs[starts[0] + 1]), 32'h0A);
            check("ff_img_pad", 32'(obs[ends[0] - 3]), 32'hBF);
            check("zero_img_b0", 32'(obs[starts[1]]), 32'hF3);
            check("zero_img_b1", 32'(obs[starts[1] + 1]), 32'hFA);
            check("stuff_ff", 32'(obs[starts[2] + 8]), 32'hFF);
            check("stuff_00", 32'(obs[starts[2] + 9]), 32'h00);
            check("repeat_len", 32'(ends[3] - starts[3]), 32'(ends[2] - starts[2]));
            ndiff = 0;
            for (int i = 0; i < ends[2] - starts[2] && starts[3] + i < obs.size(); i++)
                if (obs[starts[2] + i] != obs[starts[3] + i]) ndiff++;
            check("repeat_diffs", 32'(ndiff), 32'd0);
            check("gray_len", 32'(ends[4] - starts[4]), 32'd194);
            check("gray_b0", 32'(obs[starts[4]]), 32'h28);
            check("gray_b1", 32'(obs[starts[4] + 1]), 32'hA2);
            check("gray_b2", 32'(obs[starts[4] + 2]), 32'h8A);
            check("gray_tail", 32'({obs[ends[4] - 5], obs[ends[4] - 4], obs[ends[4] - 3]}), 32'h28A28A);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/jpeg_dc_encoder.md
Name: jpeg_dc_encoder

Overview:
- Streaming grayscale JPEG-style encoder for a fixed-size raster image. Input is one 8-bit pixel per cycle in raster order.
- Pixels are grouped into 8x8 blocks. Per block: the DCT DC term is computed, quantized, DPCM-coded and Huffman-coded with the baseline luminance DC table. Every AC coefficient is treated as zero, so each block is followed by an EOB code.
- Output is the byte-stuffed entropy-coded segment, one byte per cycle, terminated by an EOI marker per image.
- The block sits between the pixel source and the byte sink/host link.

Parameters:
- IMG_W, 128, image width in pixels (multiple of 8).
- IMG_H, 128, image height in pixels (multiple of 8).
- Q_SHIFT, 4, DC quantizer is 2^Q_SHIFT.
- FIFO_DEPTH, 16, output byte FIFO depth.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- din  in  8  pixel, unsigned.
- din_valid  in  1  pixel qualifier; a pixel is consumed on every rising edge where din_valid=1.
- dout  out  8  output byte.
- dout_valid  out  1  dout qualifier; exactly one cycle per byte, no backpressure.
- full  out  1  backpressure hint to the source.

Behaviour:
- Reset (async, nrst=0):
  - x/y counters, block accumulators, DC predictor, bit packer and FIFO are cleared.
  - dout=0, dout_valid=0, full=0.
  - Reset mid-image discards the partial image; encoding restarts at pixel (0,0).
- Pixel counting: x increments per accepted pixel and wraps at IMG_W-1; y then increments and wraps at IMG_H-1. Images run back to back with no gap cycles.
- Accumulation: IMG_W/8 accumulators of 14 bits each. Accumulator for block column k=x>>3 adds din. It is cleared (loaded with din) on the first pixel of each block (x%8==0, y%8==0).
- Block completion: at pixel x%8==7, y%8==7, the block sum S is final and is dispatched that cycle. Blocks are emitted left to right, top to bottom, one per 8 cycles at most.
- DC quantization, signed arithmetic: DC = (S - 8192 + 2^(2+Q_SHIFT)) >>> (3+Q_SHIFT). With default Q_SHIFT=4 the result range is [-64,64].
- DPCM: diff = DC - pred, then pred = DC. pred resets to 0 at the start of every image.
- Category: cat = bit length of |diff|, with cat=0 for diff=0.
- Huffman codes, MSB first: cat0 00, cat1 010, cat2 011, cat3 100, cat4 101, cat5 110, cat6 1110, cat7 11110, cat8 111110, cat9 1111110, cat10 11111110, cat11 111111110.
- Amplitude bits: the cat low bits of diff if diff>0, or of diff-1 if diff<0. These are followed by EOB 1010.
- Bit packer:
  - Bits are packed MSB first into bytes.
  - Each completed byte is pushed to the FIFO.
  - A 0xFF data byte is followed by a stuffed 0x00.
- End of image, after the last block's bits:
  - Pad to a byte boundary with 1s; the stuffing rule applies to the padded byte.
  - Then push 0xFF 0xD9 with no stuffing.
- FIFO:
  - Pops one byte per cycle whenever non-empty; dout_valid=1 on that cycle.
  - First byte of a block appears at most 12 cycles after the block-completion pixel is accepted.
- full:
  - Registered; asserted when FIFO occupancy >= FIFO_DEPTH-8.
  - With defaults and continuous 1 pixel/cycle input it never asserts.
  - If din_valid=1 while full=1, the pixel is still consumed. FIFO overflow drops the newest byte (sticky error-free; source must honor full).
- Simultaneous end-of-image and first pixel of the next image: both are handled; the predictor reset applies to the first block of the new image only.

Test Plan:
- All pixels 0x80, one image -> every block diff=0, 6 bits 001010. Output is bytes 28 A2 8A repeated 64 times (192 bytes, no pad), then FF D9; 194 bytes total.
- All pixels 0xFF -> first block DC=64, bits 11110 1000000 1010 = F4 0A. Remaining 255 blocks give 001010 each. Last data byte is BF (bits 10 + six 1s), then FF D9.
- All pixels 0x00 -> first bytes F3 FA (diff=-64, amplitude 0111111). Image ends with pad + FF D9.
- Two identical images back to back with din_valid held high -> the second image's byte stream is identical to the first (predictor reset per image).
- Stimulus whose entropy stream yields a 0xFF data byte -> 0x00 immediately follows it. No 0x00 is inserted after the EOI FF.
- Assert nrst mid-image for 2 cycles, then restart a 0x80 image -> dout_valid=0 during reset. The output equals the first scenario exactly.
